// File: rtl/lookup_arbiter_if.sv
// Requester, lookup-engine and response signals of lookup_arbiter bundled as one interface.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface lookup_arbiter_if #(
   parameter int P_REQ_NUM = 4
);
   logic [P_REQ_NUM-1:0]    i_req_valid;
   logic [48*P_REQ_NUM-1:0] i_req_mac;
   logic [P_REQ_NUM-1:0]    o_req_ready;

   logic [47:0]             o_check_mac;
   logic [3:0]              o_check_id;
   logic                    o_check_valid;

   logic                    i_result_valid;
   logic [3:0]              i_check_id;
   logic [2:0]              i_outport;
   logic [1:0]              i_seek_flag;

   logic [P_REQ_NUM-1:0]    o_rsp_valid;
   logic [2:0]              o_rsp_outport;
   logic [1:0]              o_rsp_seek_flag;
   logic                    o_rsp_timeout;
   logic [15:0]             o_err_cnt;

   modport slave (
      input  i_req_valid, i_req_mac, i_result_valid, i_check_id, i_outport, i_seek_flag,
      output o_req_ready, o_check_mac, o_check_id, o_check_valid,
             o_rsp_valid, o_rsp_outport, o_rsp_seek_flag, o_rsp_timeout, o_err_cnt
   );

   modport master (
      output i_req_valid, i_req_mac, i_result_valid, i_check_id, i_outport, i_seek_flag,
      input  o_req_ready, o_check_mac, o_check_id, o_check_valid,
             o_rsp_valid, o_rsp_outport, o_rsp_seek_flag, o_rsp_timeout, o_err_cnt
   );
endinterface

// File: rtl/lookup_arbiter.sv
// Round-robin sharing of one MAC lookup port among P_REQ_NUM requesters.
// Results are routed back by tag, and lookups whose result never returns are timed out.
module lookup_arbiter #(
   parameter int P_REQ_NUM = 4,
   parameter int P_TIMEOUT = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   lookup_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t               state_q [P_REQ_NUM];
   state_t               state_d [P_REQ_NUM];
   logic [47:0]          mac_q   [P_REQ_NUM];
   logic [47:0]          mac_d   [P_REQ_NUM];
   logic [15:0]          tmr_q   [P_REQ_NUM];
   logic [15:0]          tmr_d   [P_REQ_NUM];

   logic [3:0]           ptr_q, ptr_d;
   logic                 check_valid_q, check_valid_d;
   logic [47:0]          check_mac_q, check_mac_d;
   logic [3:0]           check_id_q, check_id_d;
   logic [P_REQ_NUM-1:0] rsp_valid_q, rsp_valid_d;
   logic [2:0]           rsp_outport_q, rsp_outport_d;
   logic [1:0]           rsp_seek_q, rsp_seek_d;
   logic                 rsp_timeout_q, rsp_timeout_d;
   logic [15:0]          err_cnt_q, err_cnt_d;

   logic [P_REQ_NUM-1:0] ready_w;
   logic [47:0]          req_mac_w [P_REQ_NUM];
   logic [P_REQ_NUM-1:0] gnt_oh, res_oh, to_oh;
   logic                 gnt_found, res_hit, to_found;

   genvar gi;
   generate
      for (gi = 0; gi < P_REQ_NUM; gi++) begin : g_req
         assign ready_w[gi]   = (state_q[gi] == ST_IDLE);
         assign req_mac_w[gi] = bus.i_req_mac[48*gi +: 48];
      end
   endgenerate

   always_comb begin
      gnt_oh    = '0;
      gnt_found = 1'b0;
      res_oh    = '0;
      res_hit   = 1'b0;
      to_oh     = '0;
      to_found  = 1'b0;

      // Grant: the first PEND at or after the pointer, otherwise the first PEND from index 0.
      for (int k = 0; k < P_REQ_NUM; k++) begin
         if (!gnt_found && state_q[k] == ST_PEND && k >= int'(ptr_q)) begin
            gnt_oh[k] = 1'b1;
            gnt_found = 1'b1;
         end
      end
      for (int k = 0; k < P_REQ_NUM; k++) begin
         if (!gnt_found && state_q[k] == ST_PEND) begin
            gnt_oh[k] = 1'b1;
            gnt_found = 1'b1;
         end
      end

      for (int k = 0; k < P_REQ_NUM; k++) begin
         if (bus.i_result_valid && bus.i_check_id == 4'(k + 1) && state_q[k] == ST_WAIT) begin
            res_oh[k] = 1'b1;
            res_hit   = 1'b1;
         end
      end

      // When a result responds this cycle, any expiring timeout waits one cycle to keep rsp one-hot.
      for (int k = 0; k < P_REQ_NUM; k++) begin
         if (!res_hit && !to_found && state_q[k] == ST_WAIT &&
             tmr_q[k] == 16'(P_TIMEOUT - 1)) begin
            to_oh[k] = 1'b1;
            to_found = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d         = ptr_q;
      check_valid_d = 1'b0;
      check_mac_d   = check_mac_q;
      check_id_d    = check_id_q;
      rsp_valid_d   = '0;
      rsp_outport_d = rsp_outport_q;
      rsp_seek_d    = rsp_seek_q;
      rsp_timeout_d = rsp_timeout_q;
      err_cnt_d     = err_cnt_q;

      for (int k = 0; k < P_REQ_NUM; k++) begin
         state_d[k] = state_q[k];
         mac_d[k]   = mac_q[k];
         tmr_d[k]   = tmr_q[k];

         case (state_q[k])
            ST_IDLE: begin
               if (bus.i_req_valid[k]) begin
                  state_d[k] = ST_PEND;
                  mac_d[k]   = req_mac_w[k];
               end
            end
            ST_PEND: begin
               if (gnt_oh[k]) begin
                  state_d[k] = ST_WAIT;
                  tmr_d[k]   = 16'd0;
               end
            end
            ST_WAIT: begin
               if (res_oh[k] || to_oh[k]) begin
                  state_d[k] = ST_IDLE;
               end else if (tmr_q[k] != 16'(P_TIMEOUT - 1)) begin
                  tmr_d[k] = tmr_q[k] + 16'd1;
               end
            end
            default: state_d[k] = ST_IDLE;
         endcase

         if (gnt_oh[k]) begin
            check_valid_d = 1'b1;
            check_mac_d   = mac_q[k];
            check_id_d    = 4'(k + 1);
            ptr_d         = (k + 1 == P_REQ_NUM) ? 4'd0 : 4'(k + 1);
         end

         if (res_oh[k]) begin
            rsp_valid_d[k] = 1'b1;
            rsp_outport_d  = bus.i_outport;
            rsp_seek_d     = bus.i_seek_flag;
            rsp_timeout_d  = 1'b0;
         end else if (to_oh[k]) begin
            rsp_valid_d[k] = 1'b1;
            rsp_outport_d  = 3'd0;
            rsp_seek_d     = 2'd0;
            rsp_timeout_d  = 1'b1;
         end
      end

      if (bus.i_result_valid && !res_hit && err_cnt_q != 16'hFFFF) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < P_REQ_NUM; k++) begin
            state_q[k] <= ST_IDLE;
            mac_q[k]   <= '0;
            tmr_q[k]   <= '0;
         end
         ptr_q         <= '0;
         check_valid_q <= 1'b0;
         check_mac_q   <= '0;
         check_id_q    <= '0;
         rsp_valid_q   <= '0;
         rsp_outport_q <= '0;
         rsp_seek_q    <= '0;
         rsp_timeout_q <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         for (int k = 0; k < P_REQ_NUM; k++) begin
            state_q[k] <= state_d[k];
            mac_q[k]   <= mac_d[k];
            tmr_q[k]   <= tmr_d[k];
         end
         ptr_q         <= ptr_d;
         check_valid_q <= check_valid_d;
         check_mac_q   <= check_mac_d;
         check_id_q    <= check_id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_outport_q <= rsp_outport_d;
         rsp_seek_q    <= rsp_seek_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign bus.o_req_ready     = ready_w;
   assign bus.o_check_valid   = check_valid_q;
   assign bus.o_check_mac     = check_mac_q;
   assign bus.o_check_id      = check_id_q;
   assign bus.o_rsp_valid     = rsp_valid_q;
   assign bus.o_rsp_outport   = rsp_outport_q;
   assign bus.o_rsp_seek_flag = rsp_seek_q;
   assign bus.o_rsp_timeout   = rsp_timeout_q;
   assign bus.o_err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_lookup_arbiter.sv
// Directed bench for lookup_arbiter covering grant order, result routing, timeouts, dropped results and reset.
// Expected values are worked out by hand.
module tb_lookup_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   lookup_arbiter_if #(.P_REQ_NUM(N)) bus_if ();

   lookup_arbiter #(.P_REQ_NUM(N), .P_TIMEOUT(TO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_req(input logic [N-1:0] mask);
      bus_if.i_req_valid = mask;
      tick();
      bus_if.i_req_valid = '0;
   endtask

   task automatic pulse_result(input logic [3:0] id, input logic [2:0] op, input logic [1:0] sf);
      bus_if.i_result_valid = 1'b1;
      bus_if.i_check_id     = id;
      bus_if.i_outport      = op;
      bus_if.i_seek_flag    = sf;
      tick();
      bus_if.i_result_valid = 1'b0;
   endtask

   task automatic set_mac(input int k, input logic [47:0] mac);
      bus_if.i_req_mac[48*k +: 48] = mac;
   endtask

   initial begin
      bus_if.i_req_valid    = '0;
      bus_if.i_req_mac      = '0;
      bus_if.i_result_valid = 1'b0;
      bus_if.i_check_id     = '0;
      bus_if.i_outport      = '0;
      bus_if.i_seek_flag    = '0;
      rst = 1'b1;
      tick_n(2);
      rst = 1'b0;

      check_val("rst_ready", 64'(bus_if.o_req_ready), 64'hF);
      check_val("rst_check_valid", 64'(bus_if.o_check_valid), 64'h0);
      check_val("rst_check_id", 64'(bus_if.o_check_id), 64'h0);
      check_val("rst_rsp_valid", 64'(bus_if.o_rsp_valid), 64'h0);
      check_val("rst_err_cnt", 64'(bus_if.o_err_cnt), 64'h0);

      // Single request on requester 2
      set_mac(2, 48'h8DBC5C4A0001);
      pulse_req(4'b0100);
      check_val("t1_ready_pend", 64'(bus_if.o_req_ready), 64'hB);
      check_val("t1_no_issue_yet", 64'(bus_if.o_check_valid), 64'h0);
      tick();
      check_val("t1_issue_valid", 64'(bus_if.o_check_valid), 64'h1);
      check_val("t1_issue_id", 64'(bus_if.o_check_id), 64'h3);
      check_val("t1_issue_mac", 64'(bus_if.o_check_mac), 64'h8DBC5C4A0001);
      tick();
      check_val("t1_valid_drop", 64'(bus_if.o_check_valid), 64'h0);
      check_val("t1_id_hold", 64'(bus_if.o_check_id), 64'h3);
      pulse_result(4'd3, 3'd1, 2'd1);
      check_val("t1_rsp_valid", 64'(bus_if.o_rsp_valid), 64'h4);
      check_val("t1_rsp_outport", 64'(bus_if.o_rsp_outport), 64'h1);
      check_val("t1_rsp_seek", 64'(bus_if.o_rsp_seek_flag), 64'h1);
      check_val("t1_rsp_timeout", 64'(bus_if.o_rsp_timeout), 64'h0);
      check_val("t1_ready_back", 64'(bus_if.o_req_ready), 64'hF);
      tick();
      check_val("t1_rsp_pulse_end", 64'(bus_if.o_rsp_valid), 64'h0);
      check_val("t1_outport_hold", 64'(bus_if.o_rsp_outport), 64'h1);

      // All four at once from pointer 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < N; k++) set_mac(k, 48'hA0_0000_0000 + 48'(k));
      pulse_req(4'b1111);
      check_val("t2_ready_all_pend", 64'(bus_if.o_req_ready), 64'h0);
      for (int k = 0; k < N; k++) begin
         tick();
         check_val($sformatf("t2_grant%0d_valid", k), 64'(bus_if.o_check_valid), 64'h1);
         check_val($sformatf("t2_grant%0d_id", k), 64'(bus_if.o_check_id), 64'(k + 1));
         check_val($sformatf("t2_grant%0d_mac", k), 64'(bus_if.o_check_mac),
                   64'h00A0_0000_0000 + 64'(k));
      end
      for (int k = 0; k < N; k++) begin
         pulse_result(4'(k + 1), 3'(k + 2), 2'((k % 3) + 1));
         check_val($sformatf("t2_rsp%0d_valid", k), 64'(bus_if.o_rsp_valid), 64'(1 << k));
         check_val($sformatf("t2_rsp%0d_outport", k), 64'(bus_if.o_rsp_outport), 64'(k + 2));
      end
      check_val("t2_ready_all_idle", 64'(bus_if.o_req_ready), 64'hF);
      pulse_req(4'b1001);
      tick();
      check_val("t2b_grant_a_id", 64'(bus_if.o_check_id), 64'h1);
      tick();
      check_val("t2b_grant_b_id", 64'(bus_if.o_check_id), 64'h4);

      // No results: both requesters time out after 16 WAIT cycles
      tick_n(14);
      check_val("t3_no_rsp_early", 64'(bus_if.o_rsp_valid), 64'h0);
      tick();
      check_val("t3_to0_valid", 64'(bus_if.o_rsp_valid), 64'h1);
      check_val("t3_to0_flag", 64'(bus_if.o_rsp_timeout), 64'h1);
      check_val("t3_to0_outport", 64'(bus_if.o_rsp_outport), 64'h0);
      check_val("t3_to0_seek", 64'(bus_if.o_rsp_seek_flag), 64'h0);
      check_val("t3_to0_ready", 64'(bus_if.o_req_ready), 64'h7);
      tick();
      check_val("t3_to3_valid", 64'(bus_if.o_rsp_valid), 64'h8);
      check_val("t3_to3_flag", 64'(bus_if.o_rsp_timeout), 64'h1);
      pulse_result(4'd1, 3'd3, 2'd3);
      check_val("t3_late_no_rsp", 64'(bus_if.o_rsp_valid), 64'h0);
      check_val("t3_late_err", 64'(bus_if.o_err_cnt), 64'h1);

      // Idle: tag held, bad ids dropped
      check_val("t4_idle_valid", 64'(bus_if.o_check_valid), 64'h0);
      check_val("t4_idle_id_hold", 64'(bus_if.o_check_id), 64'h4);
      pulse_result(4'd0, 3'd2, 2'd2);
      check_val("t4_id0_err", 64'(bus_if.o_err_cnt), 64'h2);
      pulse_result(4'd7, 3'd2, 2'd2);
      check_val("t4_id7_err", 64'(bus_if.o_err_cnt), 64'h3);
      check_val("t4_id7_no_rsp", 64'(bus_if.o_rsp_valid), 64'h0);

      // Result for req0 collides with timeout of req1
      pulse_req(4'b0010);
      tick();
      check_val("t5_grant1_id", 64'(bus_if.o_check_id), 64'h2);
      tick_n(3);
      pulse_req(4'b0001);
      tick();
      check_val("t5_grant0_id", 64'(bus_if.o_check_id), 64'h1);
      tick_n(10);
      check_val("t5_quiet", 64'(bus_if.o_rsp_valid), 64'h0);
      pulse_result(4'd1, 3'd6, 2'd2);
      check_val("t5_res_valid", 64'(bus_if.o_rsp_valid), 64'h1);
      check_val("t5_res_timeout", 64'(bus_if.o_rsp_timeout), 64'h0);
      check_val("t5_res_outport", 64'(bus_if.o_rsp_outport), 64'h6);
      tick();
      check_val("t5_to_valid", 64'(bus_if.o_rsp_valid), 64'h2);
      check_val("t5_to_timeout", 64'(bus_if.o_rsp_timeout), 64'h1);
      check_val("t5_to_outport", 64'(bus_if.o_rsp_outport), 64'h0);
      check_val("t5_err_same", 64'(bus_if.o_err_cnt), 64'h3);

      // Reset while two lookups are waiting
      pulse_req(4'b1100);
      tick();
      check_val("t6_grant2_id", 64'(bus_if.o_check_id), 64'h3);
      tick();
      check_val("t6_grant3_id", 64'(bus_if.o_check_id), 64'h4);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("t6_ready", 64'(bus_if.o_req_ready), 64'hF);
      check_val("t6_check_valid", 64'(bus_if.o_check_valid), 64'h0);
      check_val("t6_check_id", 64'(bus_if.o_check_id), 64'h0);
      check_val("t6_check_mac", 64'(bus_if.o_check_mac), 64'h0);
      check_val("t6_rsp_outport", 64'(bus_if.o_rsp_outport), 64'h0);
      check_val("t6_err_cleared", 64'(bus_if.o_err_cnt), 64'h0);
      pulse_result(4'd3, 3'd1, 2'd1);
      check_val("t6_stale3_err", 64'(bus_if.o_err_cnt), 64'h1);
      pulse_result(4'd4, 3'd1, 2'd1);
      check_val("t6_stale4_err", 64'(bus_if.o_err_cnt), 64'h2);
      check_val("t6_stale_no_rsp", 64'(bus_if.o_rsp_valid), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
